// File: rtl/div_5_detector.sv
// Serial MSB-first divisibility detector: flags a nonzero accumulated value divisible by DIVISOR.
// Optional DIV_5_DETECTOR_REM_OUT_EN exposes the running remainder and the nonzero flag.
module div_5_detector #(
  parameter  int unsigned DIVISOR = 5,
  localparam int unsigned REM_W   = $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  output logic             div_5
`ifdef DIV_5_DETECTOR_REM_OUT_EN
  ,
  output logic [REM_W-1:0] rem_out,
  output logic             nonzero
`endif
);

  localparam int unsigned SUM_W = REM_W + 1;

  logic [REM_W-1:0] rem_q, rem_d;
  logic             first_1_seen_q, first_1_seen_d;
  logic [SUM_W-1:0] sum;

  // State register: remainder and first-one flag, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q          <= '0;
      first_1_seen_q <= 1'b0;
    end else begin
      rem_q          <= rem_d;
      first_1_seen_q <= first_1_seen_d;
    end
  end

  // Next state: 2*rem + bit is below 2*DIVISOR, so one conditional subtract reduces it.
  always_comb begin
    rem_d          = rem_q;
    first_1_seen_d = first_1_seen_q | in_bit;
    sum            = {rem_q, in_bit};
    if (sum >= SUM_W'(DIVISOR)) begin
      rem_d = REM_W'(sum - SUM_W'(DIVISOR));
    end else begin
      rem_d = REM_W'(sum);
    end
  end

  // Moore output decode from registered state only.
  always_comb begin
    div_5 = first_1_seen_q && (rem_q == '0);
`ifdef DIV_5_DETECTOR_REM_OUT_EN
    rem_out = rem_q;
    nonzero = first_1_seen_q;
`endif
  end

endmodule

// File: tb/tb_div_5_detector.sv
// Directed and random bench for div_5_detector at DIVISOR = 5, 3 and 7.
// Build with DIV_5_DETECTOR_REM_OUT_EN defined to also check rem_out and nonzero.
module tb_div_5_detector;

  logic clk;
  logic rst;
  logic in_bit;
  logic div5_o, div3_o, div7_o;
`ifdef DIV_5_DETECTOR_REM_OUT_EN
  logic [2:0] rem5_o;
  logic [1:0] rem3_o;
  logic [2:0] rem7_o;
  logic       nz5_o, nz3_o, nz7_o;
`endif

  int total;
  int bad;
  logic [63:0] model;

  div_5_detector #(.DIVISOR(5)) dut5 (
    .clk(clk), .rst(rst), .in_bit(in_bit), .div_5(div5_o)
`ifdef DIV_5_DETECTOR_REM_OUT_EN
    , .rem_out(rem5_o), .nonzero(nz5_o)
`endif
  );

  div_5_detector #(.DIVISOR(3)) dut3 (
    .clk(clk), .rst(rst), .in_bit(in_bit), .div_5(div3_o)
`ifdef DIV_5_DETECTOR_REM_OUT_EN
    , .rem_out(rem3_o), .nonzero(nz3_o)
`endif
  );

  div_5_detector #(.DIVISOR(7)) dut7 (
    .clk(clk), .rst(rst), .in_bit(in_bit), .div_5(div7_o)
`ifdef DIV_5_DETECTOR_REM_OUT_EN
    , .rem_out(rem7_o), .nonzero(nz7_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Enter at a negedge, apply one bit, return at the next negedge for sampling.
  task automatic shift_bit(input logic b);
    in_bit = b;
    model  = {model[62:0], b};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic shift_chk(input string tag, input logic b, input logic exp);
    shift_bit(b);
    chk(tag, 64'(div5_o), 64'(exp));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pulse", 64'(div5_o), 64'd0);
    rst   = 1'b0;
    model = '0;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    model  = '0;
    rst    = 1'b1;
    in_bit = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_hold", 64'(div5_o), 64'd0);
    end
    rst = 1'b0;
    #1;
    chk("rst_rel", 64'(div5_o), 64'd0);
    @(negedge clk);

    // Leading zeros: value stays 0 and is not reported.
    for (int i = 0; i < 4; i++) shift_chk("zeros", 1'b0, 1'b0);

    // 1,0,1 = 5; then 10; then 21.
    shift_chk("v1", 1'b1, 1'b0);
    shift_chk("v2", 1'b0, 1'b0);
    shift_chk("v5", 1'b1, 1'b1);
    shift_chk("v10", 1'b0, 1'b1);
    shift_chk("v21", 1'b1, 1'b0);

    // 1,3,7,15,30,60,120,240.
    do_reset();
    shift_chk("v1b", 1'b1, 1'b0);
    shift_chk("v3", 1'b1, 1'b0);
    shift_chk("v7", 1'b1, 1'b0);
    shift_chk("v15", 1'b1, 1'b1);
    shift_chk("v30", 1'b0, 1'b1);
    shift_chk("v60", 1'b0, 1'b1);
    shift_chk("v120", 1'b0, 1'b1);
    shift_chk("v240", 1'b0, 1'b1);

    // Reset mid-stream while div_5 is high: must drop without a clock edge.
    do_reset();
    shift_chk("m1", 1'b1, 1'b0);
    shift_chk("m2", 1'b0, 1'b0);
    shift_chk("m5", 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst", 64'(div5_o), 64'd0);
    @(negedge clk);
    chk("async_hold", 64'(div5_o), 64'd0);
    rst   = 1'b0;
    model = '0;
    shift_chk("n1", 1'b1, 1'b0);
    shift_chk("n2", 1'b0, 1'b0);
    shift_chk("n4", 1'b0, 1'b0);
    shift_chk("n9", 1'b1, 1'b0);
    shift_chk("n19", 1'b1, 1'b0);

    // Random stream against a shift-register model for three divisors.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      shift_bit(1'($urandom_range(0, 1)));
      chk("rnd_d5", 64'(div5_o), 64'((model % 64'd5 == 64'd0) && (model != 64'd0)));
      chk("rnd_d3", 64'(div3_o), 64'((model % 64'd3 == 64'd0) && (model != 64'd0)));
      chk("rnd_d7", 64'(div7_o), 64'((model % 64'd7 == 64'd0) && (model != 64'd0)));
`ifdef DIV_5_DETECTOR_REM_OUT_EN
      chk("rem5", 64'(rem5_o), model % 64'd5);
      chk("rem3", 64'(rem3_o), model % 64'd3);
      chk("rem7", 64'(rem7_o), model % 64'd7);
      chk("nz5", 64'(nz5_o), 64'(model != 64'd0));
      chk("nz3", 64'(nz3_o), 64'(model != 64'd0));
      chk("nz7", 64'(nz7_o), 64'(model != 64'd0));
`endif
    end

`ifdef DIV_5_DETECTOR_REM_OUT_EN
    rst = 1'b1;
    #1;
    chk("rem5_rst", 64'(rem5_o), 64'd0);
    chk("nz5_rst", 64'(nz5_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
